// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by the fetch interface, FIFO and top.
package if_fetch_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] PcStep      = 32'd4;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_ent_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/grant/response bundle.
// master = fetch stage, slave = instruction memory.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   req;
    logic [InstAddrBus-1:0] addr;
    logic                   gnt;
    logic                   rvalid;
    logic [InstBus-1:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, inst} buffer between memory responses and the IF/ID register.
// Flush empties it and overrides any push or pop in the same cycle.
module fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_ent_t din,
    output logic [1:0] count,
    output fetch_ent_t head
);

    fetch_ent_t r_mem [2];
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else if (flush) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (push) r_wp <= ~r_wp;
            if (pop)  r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push == WriteEnable && !flush) begin
            r_mem[r_wp] <= din;
        end
    end

    assign count = r_cnt;
    assign head  = r_mem[r_rp];

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: PC, fetch credit/drop accounting and the IF/ID output register.
// Redirect (flush) overrides stall and discards every in-flight response.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] flush_pc_i,
    if_fetch_if.master             imem,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   valid_o
);

    logic [31:0] r_pc;
    logic [31:0] r_resp_pc;
    logic [1:0]  r_inflight;
    logic [1:0]  r_drop;
    logic [31:0] r_pc_o;
    logic [31:0] r_inst_o;
    logic        r_valid_o;

    logic [1:0]  w_count;
    fetch_ent_t  w_head;
    fetch_ent_t  w_din;
    logic [2:0]  w_credit;
    logic        w_req;
    logic        w_gnt;
    logic        w_rsp;
    logic        w_keep;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_target;

    // Credit counts FIFO slots already promised, so a response always fits.
    assign w_credit = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_req    = (rst != RstEnable) && !flush_i && (w_credit < 3'd2);
    assign w_gnt    = w_req && imem.gnt;
    assign w_rsp    = imem.rvalid && (r_inflight != 2'd0);
    assign w_keep   = w_rsp && (r_drop == 2'd0);
    assign w_push   = w_keep && !flush_i;
    assign w_pop    = !flush_i && !stall_i && (w_count != 2'd0);
    assign w_target = word_align(flush_pc_i);
    assign w_din    = '{pc: r_resp_pc, inst: imem.rdata};

    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush_i),
        .din   (w_din),
        .count (w_count),
        .head  (w_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= 2'd0;
            r_drop     <= 2'd0;
            r_pc_o     <= ZeroWord;
            r_inst_o   <= ZeroWord;
            r_valid_o  <= 1'b0;
        end else if (flush_i) begin
            r_pc       <= w_target;
            r_resp_pc  <= w_target;
            r_inflight <= r_inflight - {1'b0, w_rsp};
            r_drop     <= r_inflight - {1'b0, w_rsp};
            r_inst_o   <= ZeroWord;
            r_valid_o  <= 1'b0;
        end else begin
            if (w_gnt)  r_pc      <= r_pc + PcStep;
            if (w_keep) r_resp_pc <= r_resp_pc + PcStep;
            r_inflight <= r_inflight + {1'b0, w_gnt} - {1'b0, w_rsp};
            if (w_rsp && r_drop != 2'd0) r_drop <= r_drop - 2'd1;
            if (!stall_i) begin
                if (w_count != 2'd0) begin
                    r_pc_o    <= w_head.pc;
                    r_inst_o  <= w_head.inst;
                    r_valid_o <= 1'b1;
                end else begin
                    r_inst_o  <= ZeroWord;
                    r_valid_o <= 1'b0;
                end
            end
        end
    end

    assign pc_o    = r_pc_o;
    assign inst_o  = r_inst_o;
    assign valid_o = r_valid_o;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: grants push expectations, a negedge monitor pops them.
// A second instance exercises PC wrap from RESET_PC = 0xFFFF_FFF8.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    if_fetch_if m ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .imem       (m),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .valid_o    (valid_o)
    );

    logic        rst2 = 1'b0;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        val2;

    if_fetch_if m2 ();

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .stall_i    (1'b0),
        .flush_i    (1'b0),
        .flush_pc_i (32'h0),
        .imem       (m2),
        .pc_o       (pc2),
        .inst_o     (inst2),
        .valid_o    (val2)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] expq [$];
    logic [31:0] memq [$];
    logic        hold = 1'b0;
    int          mcyc = 0;
    int          first_gnt = -1;
    int          first_val = -1;
    logic        ld = 1'b0;
    logic        fl_d = 1'b0;
    logic        st_d = 1'b0;
    logic [64:0] prev = '0;
    logic [63:0] mon_e;
    logic        last_req;
    logic [31:0] last_addr;

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic step(input logic st, input logic fl, input logic [31:0] fpc);
        stall_i    = st;
        flush_i    = fl;
        flush_pc_i = fpc;
        m.gnt      = 1'b1;
        if (!hold && memq.size() > 0) begin
            m.rvalid = 1'b1;
            m.rdata  = memq.pop_front() ^ KEY;
        end else begin
            m.rvalid = 1'b0;
            m.rdata  = 32'h0;
        end
        #1;
        last_req  = m.req;
        last_addr = m.addr;
        if (m.req && m.gnt) begin
            memq.push_back(m.addr);
            expq.push_back({m.addr, m.addr ^ KEY});
            if (first_gnt < 0) first_gnt = mcyc;
        end
        if (fl) expq.delete();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        ld   <= rst && !stall_i && !flush_i;
        fl_d <= rst && flush_i;
        st_d <= rst && stall_i && !flush_i;
    end

    always @(negedge clk) begin
        mcyc++;
        if (ld && valid_o) begin
            if (first_val < 0) first_val = mcyc;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got pc %h inst %h, none expected",
                         pc_o, inst_o);
            end else begin
                mon_e = expq.pop_front();
                chk("out_pc", {33'h0, pc_o}, {33'h0, mon_e[63:32]});
                chk("out_inst", {33'h0, inst_o}, {33'h0, mon_e[31:0]});
            end
        end
        if (fl_d) chk("flush_clears", {32'h0, valid_o, inst_o}, 65'h0);
        if (st_d) chk("stall_hold", {valid_o, pc_o, inst_o}, prev);
        prev = {valid_o, pc_o, inst_o};
    end

    logic [31:0] gaddr [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [31:0] opc   [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [31:0] oinst0 = 32'hDEAD_BEEF;
    int          ng2 = 0;
    int          no2 = 0;
    logic        p2 = 1'b0;
    logic [31:0] pa2 = 32'h0;

    initial begin
        m2.gnt    = 1'b1;
        m2.rvalid = 1'b0;
        m2.rdata  = 32'h0;
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        forever begin
            #1;
            p2  = m2.req;
            pa2 = m2.addr;
            if (m2.req && ng2 < 3) begin
                gaddr[ng2] = m2.addr;
                ng2++;
            end
            @(negedge clk);
            m2.rvalid = p2;
            m2.rdata  = pa2 ^ KEY;
            if (val2 && no2 < 3) begin
                opc[no2] = pc2;
                if (no2 == 0) oinst0 = inst2;
                no2++;
            end
        end
    end

    initial begin
        int n;
        m.gnt    = 1'b0;
        m.rvalid = 1'b0;
        m.rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {64'h0, valid_o}, 65'h0);
        chk("rst_pc", {33'h0, pc_o}, 65'h0);
        chk("rst_inst", {33'h0, inst_o}, 65'h0);
        chk("rst_req", {64'h0, m.req}, 65'h0);
        chk("rst_addr", {33'h0, m.addr}, 65'h0);

        rst = 1'b1;
        #1;
        chk("first_req", {64'h0, m.req}, 65'h1);
        repeat (14) step(1'b0, 1'b0, 32'h0);
        chk("latency", 65'(first_val - first_gnt), 65'd3);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (i >= 2) chk("stall_req_low", {64'h0, last_req}, 65'h0);
        end
        repeat (10) step(1'b0, 1'b0, 32'h0);

        hold = 1'b1;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("credit_full", {64'h0, last_req}, 65'h0);
        step(1'b0, 1'b1, 32'h0000_0103);
        chk("flush_noreq", {64'h0, last_req}, 65'h0);
        hold = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        chk("redirect_addr", {33'h0, last_addr}, {33'h0, 32'h0000_0100});
        repeat (10) step(1'b0, 1'b0, 32'h0);

        n = 0;
        while (memq.size() == 0 && n < 6) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("rsp_pending", {64'h0, memq.size() > 0}, 65'h1);
        step(1'b1, 1'b1, 32'h0000_0200);
        chk("flush2_noreq", {64'h0, last_req}, 65'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("redirect2_addr", {33'h0, last_addr}, {33'h0, 32'h0000_0200});
        repeat (8) step(1'b0, 1'b0, 32'h0);

        n = 0;
        while (!valid_o && n < 6) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("pre_rst_valid", {64'h0, valid_o}, 65'h1);
        #2;
        rst = 1'b0;
        m.rvalid = 1'b0;
        #1;
        chk("arst_valid", {64'h0, valid_o}, 65'h0);
        chk("arst_req", {64'h0, m.req}, 65'h0);
        chk("arst_addr", {33'h0, m.addr}, 65'h0);
        memq.delete();
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) step(1'b0, 1'b0, 32'h0);

        chk("wrap_gnt0", {33'h0, gaddr[0]}, {33'h0, 32'hFFFF_FFF8});
        chk("wrap_gnt1", {33'h0, gaddr[1]}, {33'h0, 32'hFFFF_FFFC});
        chk("wrap_gnt2", {33'h0, gaddr[2]}, 65'h0);
        chk("wrap_out0", {33'h0, opc[0]}, {33'h0, 32'hFFFF_FFF8});
        chk("wrap_out1", {33'h0, opc[1]}, {33'h0, 32'hFFFF_FFFC});
        chk("wrap_out2", {33'h0, opc[2]}, 65'h0);
        chk("wrap_inst0", {33'h0, oinst0}, {33'h0, 32'hFFFF_FFF8 ^ KEY});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
